// File: rtl/status_register_unit.sv
// ---------------------------------------------------------------------------
// status_register_unit
//
// Holds the architectural {N,Z,C,V} condition flags, a shadow copy taken on
// exception entry (SPSR-like), and a small two-state exception FSM.
// Flag writes from the EXE stage commit when the instruction is valid,
// requests an update, passes its condition, and is neither flushed nor
// stalled. Per-cycle priority: rst > freeze > exc_return > exc_enter >
// flag write.
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   synchronous active-high reset
//   exe_valid    in   EXE stage holds a real instruction
//   s_bit        in   instruction requests flag update
//   cond_pass    in   condition check result for the EXE instruction
//   alu_flags    in   [3:0] {N,Z,C,V} from the ALU
//   freeze       in   pipeline stall, all state held
//   flush        in   cancel the EXE instruction
//   exc_enter    in   exception entry request
//   exc_return   in   exception return request
//   status       out  [3:0] current flags (registered)
//   saved_status out  [3:0] shadow flags
//   in_exc       out  high while in EXC state (registered)
//   exc_err      out  sticky protocol-error flag
//   upd_cnt      out  [CNT_W-1:0] saturating count of committed flag writes
// ---------------------------------------------------------------------------
module status_register_unit #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             exe_valid,
   input  logic             s_bit,
   input  logic             cond_pass,
   input  logic [3:0]       alu_flags,
   input  logic             freeze,
   input  logic             flush,
   input  logic             exc_enter,
   input  logic             exc_return,
   output logic [3:0]       status,
   output logic [3:0]       saved_status,
   output logic             in_exc,
   output logic             exc_err,
   output logic [CNT_W-1:0] upd_cnt
);

   typedef enum logic [0:0] {
      ST_NORMAL = 1'b0,
      ST_EXC    = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           r_state;
   logic [3:0]       r_status;
   logic [3:0]       r_saved;
   logic             r_in_exc;
   logic             r_err;
   logic [CNT_W-1:0] r_cnt;

   logic w_wr;
   logic w_ret_acc;
   logic w_ent_acc;
   logic w_commit;

   assign w_wr      = exe_valid & s_bit & cond_pass & ~flush & ~freeze;
   // Return outranks entry, so an entry is only accepted without a return.
   assign w_ret_acc = exc_return & (r_state == ST_EXC);
   assign w_ent_acc = exc_enter & ~exc_return & (r_state == ST_NORMAL);
   // Ignored exception requests do not block a flag write; accepted ones do.
   assign w_commit  = w_wr & ~w_ret_acc & ~w_ent_acc;

   // Exception FSM, flag registers, error flag and update counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_NORMAL;
         r_status <= 4'b0000;
         r_saved  <= 4'b0000;
         r_in_exc <= 1'b0;
         r_err    <= 1'b0;
         r_cnt    <= {CNT_W{1'b0}};
      end else if (!freeze) begin
         case (r_state)
            ST_NORMAL: begin
               if (exc_return) begin
                  r_err <= 1'b1;
               end else if (exc_enter) begin
                  // Shadow the pre-write value; any same-cycle write is dropped.
                  r_saved  <= r_status;
                  r_state  <= ST_EXC;
                  r_in_exc <= 1'b1;
               end else begin
                  r_state <= ST_NORMAL;
               end
            end
            ST_EXC: begin
               if (exc_return) begin
                  r_status <= r_saved;
                  r_state  <= ST_NORMAL;
                  r_in_exc <= 1'b0;
               end else if (exc_enter) begin
                  // Nested entry is not supported: keep the shadow, flag it.
                  r_err <= 1'b1;
               end else begin
                  r_state <= ST_EXC;
               end
            end
            default: begin
               r_state  <= ST_NORMAL;
               r_in_exc <= 1'b0;
            end
         endcase

         if (w_commit) begin
            r_status <= alu_flags;
            if (r_cnt != CNT_MAX) begin
               r_cnt <= r_cnt + CNT_ONE;
            end
         end
      end
   end

   assign status       = r_status;
   assign saved_status = r_saved;
   assign in_exc       = r_in_exc;
   assign exc_err      = r_err;
   assign upd_cnt      = r_cnt;

endmodule

// File: tb/tb_status_register_unit.sv
// ---------------------------------------------------------------------------
// tb_status_register_unit
//
// Self-checking bench. Each row of a stimulus table drives one cycle and
// pushes the expected outputs to a scoreboard queue; after the clock edge the
// entry is popped and compared against the DUT. A second instance with
// CNT_W=2 shares all inputs and is used to check counter saturation.
// ---------------------------------------------------------------------------
module tb_status_register_unit;

   typedef struct {
      logic       rst;
      logic       ev;
      logic       s;
      logic       cp;
      logic [3:0] fl;
      logic       fz;
      logic       fls;
      logic       en;
      logic       ret;
      logic [3:0] st;
      logic [3:0] sv;
      logic       ie;
      logic       er;
      logic [7:0] cnt;
   } step_t;

   typedef struct {
      logic [3:0] st;
      logic [3:0] sv;
      logic       ie;
      logic       er;
      logic [7:0] cnt;
      logic [1:0] c2;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       exe_valid;
   logic       s_bit;
   logic       cond_pass;
   logic [3:0] alu_flags;
   logic       freeze;
   logic       flush;
   logic       exc_enter;
   logic       exc_return;
   logic [3:0] status;
   logic [3:0] saved_status;
   logic       in_exc;
   logic       exc_err;
   logic [7:0] upd_cnt;
   logic [3:0] status2;
   logic [3:0] saved_status2;
   logic       in_exc2;
   logic       exc_err2;
   logic [1:0] upd_cnt2;

   exp_t exp_q[$];
   int   n_cmp;
   int   n_bad;

   status_register_unit #(.CNT_W(8)) dut (
      .clk(clk), .rst(rst), .exe_valid(exe_valid), .s_bit(s_bit),
      .cond_pass(cond_pass), .alu_flags(alu_flags), .freeze(freeze),
      .flush(flush), .exc_enter(exc_enter), .exc_return(exc_return),
      .status(status), .saved_status(saved_status), .in_exc(in_exc),
      .exc_err(exc_err), .upd_cnt(upd_cnt)
   );

   status_register_unit #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .exe_valid(exe_valid), .s_bit(s_bit),
      .cond_pass(cond_pass), .alu_flags(alu_flags), .freeze(freeze),
      .flush(flush), .exc_enter(exc_enter), .exc_return(exc_return),
      .status(status2), .saved_status(saved_status2), .in_exc(in_exc2),
      .exc_err(exc_err2), .upd_cnt(upd_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic step_t mk(
      input logic a_rst, input logic a_ev, input logic a_s, input logic a_cp,
      input logic [3:0] a_fl, input logic a_fz, input logic a_fls,
      input logic a_en, input logic a_ret,
      input logic [3:0] e_st, input logic [3:0] e_sv, input logic e_ie,
      input logic e_er, input logic [7:0] e_cnt);
      step_t r;
      r.rst = a_rst; r.ev = a_ev; r.s = a_s; r.cp = a_cp; r.fl = a_fl;
      r.fz = a_fz; r.fls = a_fls; r.en = a_en; r.ret = a_ret;
      r.st = e_st; r.sv = e_sv; r.ie = e_ie; r.er = e_er; r.cnt = e_cnt;
      return r;
   endfunction

   // Drive one cycle of stimulus and queue what the outputs must be after it.
   task automatic drive_row(input step_t r);
      exp_t e;
      rst = r.rst; exe_valid = r.ev; s_bit = r.s; cond_pass = r.cp;
      alu_flags = r.fl; freeze = r.fz; flush = r.fls;
      exc_enter = r.en; exc_return = r.ret;
      e.st = r.st; e.sv = r.sv; e.ie = r.ie; e.er = r.er; e.cnt = r.cnt;
      e.c2 = (r.cnt > 8'd3) ? 2'd3 : r.cnt[1:0];
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step_t rows[3];
      exp_t  e;
      rows[0] = mk(1'b1,1'b1,1'b1,1'b1,4'b1111,1'b0,1'b0,1'b1,1'b0, 4'b0000,4'b0000,1'b0,1'b0,8'd0);
      rows[1] = mk(1'b1,1'b1,1'b1,1'b1,4'b1010,1'b1,1'b0,1'b0,1'b1, 4'b0000,4'b0000,1'b0,1'b0,8'd0);
      rows[2] = mk(1'b0,1'b0,1'b0,1'b0,4'b0000,1'b0,1'b0,1'b0,1'b0, 4'b0000,4'b0000,1'b0,1'b0,8'd0);
      for (int i = 0; i < 3; i++) begin
         drive_row(rows[i]);
         e = exp_q.pop_front();
         n_cmp++;
         if ({status, saved_status, in_exc, exc_err, upd_cnt, upd_cnt2} !==
             {e.st, e.sv, e.ie, e.er, e.cnt, e.c2}) begin
            n_bad++;
            $display("FAIL reset[%0d]: got st=%b sv=%b ie=%b er=%b cnt=%0d c2=%0d, want st=%b sv=%b ie=%b er=%b cnt=%0d c2=%0d",
                     i, status, saved_status, in_exc, exc_err, upd_cnt, upd_cnt2,
                     e.st, e.sv, e.ie, e.er, e.cnt, e.c2);
         end
      end
   endtask

   task automatic test_flag_write();
      step_t rows[8];
      exp_t  e;
      rows[0] = mk(1'b0,1'b1,1'b1,1'b1,4'b0100,1'b0,1'b0,1'b0,1'b0, 4'b0100,4'b0000,1'b0,1'b0,8'd1);
      rows[1] = mk(1'b0,1'b1,1'b1,1'b0,4'b1010,1'b0,1'b0,1'b0,1'b0, 4'b0100,4'b0000,1'b0,1'b0,8'd1);
      rows[2] = mk(1'b0,1'b1,1'b1,1'b1,4'b1010,1'b0,1'b1,1'b0,1'b0, 4'b0100,4'b0000,1'b0,1'b0,8'd1);
      rows[3] = mk(1'b0,1'b1,1'b1,1'b1,4'b1010,1'b1,1'b0,1'b0,1'b0, 4'b0100,4'b0000,1'b0,1'b0,8'd1);
      rows[4] = mk(1'b0,1'b1,1'b0,1'b1,4'b1010,1'b0,1'b0,1'b0,1'b0, 4'b0100,4'b0000,1'b0,1'b0,8'd1);
      rows[5] = mk(1'b0,1'b0,1'b1,1'b1,4'b1010,1'b0,1'b0,1'b0,1'b0, 4'b0100,4'b0000,1'b0,1'b0,8'd1);
      rows[6] = mk(1'b0,1'b1,1'b1,1'b1,4'b1010,1'b1,1'b0,1'b1,1'b0, 4'b0100,4'b0000,1'b0,1'b0,8'd1);
      rows[7] = mk(1'b0,1'b1,1'b1,1'b1,4'b1001,1'b0,1'b0,1'b0,1'b0, 4'b1001,4'b0000,1'b0,1'b0,8'd2);
      for (int i = 0; i < 8; i++) begin
         drive_row(rows[i]);
         e = exp_q.pop_front();
         n_cmp++;
         if ({status, saved_status, in_exc, exc_err, upd_cnt, upd_cnt2} !==
             {e.st, e.sv, e.ie, e.er, e.cnt, e.c2}) begin
            n_bad++;
            $display("FAIL flag_write[%0d]: got st=%b sv=%b ie=%b er=%b cnt=%0d c2=%0d, want st=%b sv=%b ie=%b er=%b cnt=%0d c2=%0d",
                     i, status, saved_status, in_exc, exc_err, upd_cnt, upd_cnt2,
                     e.st, e.sv, e.ie, e.er, e.cnt, e.c2);
         end
      end
   endtask

   task automatic test_exception();
      step_t rows[6];
      exp_t  e;
      rows[0] = mk(1'b0,1'b1,1'b1,1'b1,4'b0110,1'b0,1'b0,1'b1,1'b0, 4'b1001,4'b1001,1'b1,1'b0,8'd2);
      rows[1] = mk(1'b0,1'b1,1'b1,1'b1,4'b0010,1'b0,1'b0,1'b0,1'b0, 4'b0010,4'b1001,1'b1,1'b0,8'd3);
      rows[2] = mk(1'b0,1'b0,1'b0,1'b0,4'b0000,1'b1,1'b0,1'b0,1'b1, 4'b0010,4'b1001,1'b1,1'b0,8'd3);
      rows[3] = mk(1'b0,1'b0,1'b0,1'b0,4'b0000,1'b0,1'b0,1'b0,1'b1, 4'b1001,4'b1001,1'b0,1'b0,8'd3);
      rows[4] = mk(1'b0,1'b0,1'b0,1'b0,4'b0000,1'b0,1'b0,1'b1,1'b0, 4'b1001,4'b1001,1'b1,1'b0,8'd3);
      rows[5] = mk(1'b0,1'b1,1'b1,1'b1,4'b1111,1'b0,1'b0,1'b0,1'b1, 4'b1001,4'b1001,1'b0,1'b0,8'd3);
      for (int i = 0; i < 6; i++) begin
         drive_row(rows[i]);
         e = exp_q.pop_front();
         n_cmp++;
         if ({status, saved_status, in_exc, exc_err, upd_cnt, upd_cnt2} !==
             {e.st, e.sv, e.ie, e.er, e.cnt, e.c2}) begin
            n_bad++;
            $display("FAIL exception[%0d]: got st=%b sv=%b ie=%b er=%b cnt=%0d c2=%0d, want st=%b sv=%b ie=%b er=%b cnt=%0d c2=%0d",
                     i, status, saved_status, in_exc, exc_err, upd_cnt, upd_cnt2,
                     e.st, e.sv, e.ie, e.er, e.cnt, e.c2);
         end
      end
   endtask

   task automatic test_errors();
      step_t rows[11];
      exp_t  e;
      rows[0]  = mk(1'b0,1'b0,1'b0,1'b0,4'b0000,1'b0,1'b0,1'b1,1'b0, 4'b1001,4'b1001,1'b1,1'b0,8'd3);
      rows[1]  = mk(1'b0,1'b1,1'b1,1'b1,4'b0011,1'b0,1'b0,1'b0,1'b0, 4'b0011,4'b1001,1'b1,1'b0,8'd4);
      rows[2]  = mk(1'b0,1'b0,1'b0,1'b0,4'b0000,1'b0,1'b0,1'b1,1'b0, 4'b0011,4'b1001,1'b1,1'b1,8'd4);
      rows[3]  = mk(1'b0,1'b0,1'b0,1'b0,4'b0000,1'b0,1'b0,1'b0,1'b1, 4'b1001,4'b1001,1'b0,1'b1,8'd4);
      rows[4]  = mk(1'b0,1'b1,1'b1,1'b1,4'b0101,1'b0,1'b0,1'b0,1'b1, 4'b0101,4'b1001,1'b0,1'b1,8'd5);
      rows[5]  = mk(1'b0,1'b0,1'b0,1'b0,4'b0000,1'b0,1'b0,1'b1,1'b1, 4'b0101,4'b1001,1'b0,1'b1,8'd5);
      rows[6]  = mk(1'b0,1'b0,1'b0,1'b0,4'b0000,1'b0,1'b0,1'b0,1'b0, 4'b0101,4'b1001,1'b0,1'b1,8'd5);
      rows[7]  = mk(1'b0,1'b1,1'b1,1'b1,4'b1111,1'b0,1'b0,1'b0,1'b0, 4'b1111,4'b1001,1'b0,1'b1,8'd6);
      rows[8]  = mk(1'b0,1'b0,1'b0,1'b0,4'b0000,1'b0,1'b0,1'b1,1'b0, 4'b1111,4'b1111,1'b1,1'b1,8'd6);
      rows[9]  = mk(1'b1,1'b1,1'b1,1'b1,4'b0110,1'b0,1'b0,1'b1,1'b0, 4'b0000,4'b0000,1'b0,1'b0,8'd0);
      rows[10] = mk(1'b0,1'b0,1'b0,1'b0,4'b0000,1'b0,1'b0,1'b0,1'b0, 4'b0000,4'b0000,1'b0,1'b0,8'd0);
      for (int i = 0; i < 11; i++) begin
         drive_row(rows[i]);
         e = exp_q.pop_front();
         n_cmp++;
         if ({status, saved_status, in_exc, exc_err, upd_cnt, upd_cnt2} !==
             {e.st, e.sv, e.ie, e.er, e.cnt, e.c2}) begin
            n_bad++;
            $display("FAIL errors[%0d]: got st=%b sv=%b ie=%b er=%b cnt=%0d c2=%0d, want st=%b sv=%b ie=%b er=%b cnt=%0d c2=%0d",
                     i, status, saved_status, in_exc, exc_err, upd_cnt, upd_cnt2,
                     e.st, e.sv, e.ie, e.er, e.cnt, e.c2);
         end
      end
   endtask

   task automatic test_saturation();
      step_t rows[6];
      exp_t  e;
      rows[0] = mk(1'b0,1'b1,1'b1,1'b1,4'b0001,1'b0,1'b0,1'b0,1'b0, 4'b0001,4'b0000,1'b0,1'b0,8'd1);
      rows[1] = mk(1'b0,1'b1,1'b1,1'b1,4'b0010,1'b0,1'b0,1'b0,1'b0, 4'b0010,4'b0000,1'b0,1'b0,8'd2);
      rows[2] = mk(1'b0,1'b1,1'b1,1'b1,4'b0011,1'b0,1'b0,1'b0,1'b0, 4'b0011,4'b0000,1'b0,1'b0,8'd3);
      rows[3] = mk(1'b0,1'b1,1'b1,1'b1,4'b0100,1'b0,1'b0,1'b0,1'b0, 4'b0100,4'b0000,1'b0,1'b0,8'd4);
      rows[4] = mk(1'b0,1'b1,1'b1,1'b1,4'b0101,1'b0,1'b0,1'b0,1'b0, 4'b0101,4'b0000,1'b0,1'b0,8'd5);
      rows[5] = mk(1'b1,1'b0,1'b0,1'b0,4'b0000,1'b0,1'b0,1'b0,1'b0, 4'b0000,4'b0000,1'b0,1'b0,8'd0);
      for (int i = 0; i < 6; i++) begin
         drive_row(rows[i]);
         e = exp_q.pop_front();
         n_cmp++;
         if ({status, saved_status, in_exc, exc_err, upd_cnt, upd_cnt2} !==
             {e.st, e.sv, e.ie, e.er, e.cnt, e.c2}) begin
            n_bad++;
            $display("FAIL saturation[%0d]: got st=%b sv=%b ie=%b er=%b cnt=%0d c2=%0d, want st=%b sv=%b ie=%b er=%b cnt=%0d c2=%0d",
                     i, status, saved_status, in_exc, exc_err, upd_cnt, upd_cnt2,
                     e.st, e.sv, e.ie, e.er, e.cnt, e.c2);
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1; exe_valid = 1'b0; s_bit = 1'b0; cond_pass = 1'b0;
      alu_flags = 4'b0000; freeze = 1'b0; flush = 1'b0;
      exc_enter = 1'b0; exc_return = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_flag_write();
      test_exception();
      test_errors();
      test_saturation();
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard: %0d entries left, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/status_register_unit.md
STATUS_REGISTER_UNIT -- requirements
Module: status_register_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of flag-update counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port exe_valid  input  1  EXE stage holds a real instruction.
REQ-005 SHALL have port s_bit  input  1  instruction requests flag update.
REQ-006 SHALL have port cond_pass  input  1  result of condition check for the EXE instruction.
REQ-007 SHALL have port alu_flags  input  4  {N,Z,C,V} produced by the ALU.
REQ-008 SHALL have port freeze  input  1  pipeline stall; hold all state.
REQ-009 SHALL have port flush  input  1  cancel the EXE instruction.
REQ-010 SHALL have port exc_enter  input  1  exception entry request.
REQ-011 SHALL have port exc_return  input  1  exception return request.
REQ-012 SHALL have port status  output  4  current {N,Z,C,V}, registered, feeds condition check.
REQ-013 SHALL have port saved_status  output  4  shadow copy (SPSR).
REQ-014 SHALL have port in_exc  output  1  high in state EXC.
REQ-015 SHALL have port exc_err  output  1  sticky protocol-error flag.
REQ-016 SHALL have port upd_cnt  output  CNT_W  number of committed flag writes, saturating.

Function
REQ-017 SHALL implement a two-state FSM: NORMAL, EXC.
REQ-018 SHALL define flag write wr = exe_valid & s_bit & cond_pass & ~flush & ~freeze.
REQ-019 SHALL, on wr in a cycle with no accepted exception event, load status <= alu_flags at the next edge; visible one cycle after the write cycle.
REQ-020 SHALL hold status unchanged when s_bit=0, cond_pass=0, exe_valid=0, or flush=1.
REQ-021 SHALL, when freeze=1, hold all registers and FSM state; exc_enter/exc_return ignored that cycle (upstream re-presents them).
REQ-022 SHALL apply priority per cycle: rst > freeze > exc_return > exc_enter > flag write.
REQ-023 SHALL, in NORMAL with exc_enter=1: saved_status <= status (pre-write value), state -> EXC; any concurrent flag write is dropped.
REQ-024 SHALL, in EXC with exc_return=1: status <= saved_status, state -> NORMAL; concurrent flag write dropped.
REQ-025 SHALL, in EXC with exc_enter=1 (nested), ignore the request, keep saved_status, and set exc_err.
REQ-026 SHALL, in NORMAL with exc_return=1, ignore the request and set exc_err.
REQ-027 SHALL, when exc_enter and exc_return both high, treat per REQ-022 (return wins; in NORMAL this sets exc_err and no entry occurs).
REQ-028 SHALL permit flag writes in EXC state; they modify status only, never saved_status.
REQ-029 SHALL increment upd_cnt by 1 on every committed flag write; saturate at all-ones, no wrap.
REQ-030 SHALL keep exc_err set until rst.
REQ-031 SHALL drive in_exc = (state == EXC), registered.

Reset
REQ-032 SHALL, on rst=1 at a rising edge, set status=0000, saved_status=0000, state=NORMAL, in_exc=0, exc_err=0, upd_cnt=0, regardless of all other inputs.
REQ-033 SHALL, on rst mid-exception, return to NORMAL with no restore of saved_status.

Verification
REQ-034 SHALL cover: reset, then exe_valid=1,s_bit=1,cond_pass=1,alu_flags=0100 -> status=0100 next cycle, upd_cnt=1.
REQ-035 SHALL cover: same write with cond_pass=0, then with flush=1, then with freeze=1 -> status stays 0100, upd_cnt stays 1.
REQ-036 SHALL cover: status=1001, exc_enter=1 with concurrent write 0110 -> saved_status=1001, status=1001, in_exc=1; then write 0010 -> status=0010; exc_return -> status=1001, in_exc=0.
REQ-037 SHALL cover: exc_enter twice without return -> second ignored, exc_err=1; exc_return in NORMAL -> exc_err=1, stays until rst.
REQ-038 SHALL cover: CNT_W=2, five committed writes -> upd_cnt=3 (saturated).
REQ-039 SHALL cover: rst asserted while in_exc=1 and status=1111 -> status=0000, in_exc=0, all outputs at reset values next cycle.
